tmds_encoder: RTL and testbench



---
 rtl/tmds_pkg.sv | 21 ++
 rtl/tmds_qm_stage.sv | 54 +++++
 rtl/tmds_encoder.sv | 93 +++++++++
 tb/tb_tmds_encoder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control symbols, disparity counter width and a
// byte popcount used by both encoder stages.
package tmds_pkg;

  localparam logic [9:0] TMDS_CTRL_00 = 10'h354;
  localparam logic [9:0] TMDS_CTRL_01 = 10'h0AB;
  localparam logic [9:0] TMDS_CTRL_10 = 10'h154;
  localparam logic [9:0] TMDS_CTRL_11 = 10'h2AB;

  localparam int TMDS_CNT_W = 5;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s = s + {3'b000, v[i]};
    end
    return s;
  endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// TMDS stage 1: transition-minimised 9-bit word q_m, registered together
// with vde and ctrl so stage 2 sees an aligned set.
module tmds_qm_stage
  import tmds_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       vde,
  input  logic [7:0] din,
  input  logic [1:0] ctrl,
  output logic [8:0] qm_q,
  output logic       vde_q,
  output logic [1:0] ctrl_q
);

  logic [3:0] n1;
  logic       use_xnor;
  logic       acc;
  logic [8:0] qm_new;
  logic [8:0] qm_d;
  logic       vde_d;
  logic [1:0] ctrl_d;

  always_comb begin
    n1       = popcount8(din);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !din[0]);
    qm_new   = '0;
    acc      = din[0];
    qm_new[0] = acc;
    for (int i = 1; i < 8; i++) begin
      acc       = use_xnor ? ~(acc ^ din[i]) : (acc ^ din[i]);
      qm_new[i] = acc;
    end
    qm_new[8] = ~use_xnor;

    qm_d   = ce ? qm_new : qm_q;
    vde_d  = ce ? vde    : vde_q;
    ctrl_d = ce ? ctrl   : ctrl_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      qm_q   <= '0;
      vde_q  <= 1'b0;
      ctrl_q <= 2'b00;
    end else begin
      qm_q   <= qm_d;
      vde_q  <= vde_d;
      ctrl_q <= ctrl_d;
    end
  end

endmodule

// File: rtl/tmds_encoder.sv
// Per-channel DVI TMDS 8b/10b encoder: stage 1 minimises transitions,
// stage 2 applies running-disparity DC balance or emits control symbols.
module tmds_encoder
  import tmds_pkg::*;
#(
  parameter logic [9:0] RST_SYMBOL = 10'h354
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       vde,
  input  logic [7:0] din,
  input  logic [1:0] ctrl,
  output logic [9:0] dout,
  output logic       dout_vde
);

  logic [8:0]            s1_qm;
  logic                  s1_vde;
  logic [1:0]            s1_ctrl;

  logic [3:0]            n1q;
  logic [TMDS_CNT_W-1:0] disp;
  logic                  cnt_pos;
  logic                  cnt_neg;

  logic [9:0]            dout_q, dout_d;
  logic                  dout_vde_q, dout_vde_d;
  logic [TMDS_CNT_W-1:0] cnt_q, cnt_d;

  tmds_qm_stage u_qm (
    .clk    (clk),
    .rst_n  (rst_n),
    .ce     (ce),
    .vde    (vde),
    .din    (din),
    .ctrl   (ctrl),
    .qm_q   (s1_qm),
    .vde_q  (s1_vde),
    .ctrl_q (s1_ctrl)
  );

  // disp = n1q - n0q = 2*n1q - 8; modular 5-bit math is exact because the
  // balancing rules keep cnt within -10..+10.
  always_comb begin
    n1q     = popcount8(s1_qm[7:0]);
    disp    = {n1q, 1'b0} - 5'd8;
    cnt_neg = cnt_q[TMDS_CNT_W-1];
    cnt_pos = !cnt_q[TMDS_CNT_W-1] && (cnt_q != '0);

    dout_d     = dout_q;
    dout_vde_d = dout_vde_q;
    cnt_d      = cnt_q;

    if (ce) begin
      dout_vde_d = s1_vde;
      if (!s1_vde) begin
        cnt_d = '0;
        case (s1_ctrl)
          2'b00:   dout_d = TMDS_CTRL_00;
          2'b01:   dout_d = TMDS_CTRL_01;
          2'b10:   dout_d = TMDS_CTRL_10;
          default: dout_d = TMDS_CTRL_11;
        endcase
      end else if ((cnt_q == '0) || (n1q == 4'd4)) begin
        dout_d = {~s1_qm[8], s1_qm[8], s1_qm[8] ? s1_qm[7:0] : ~s1_qm[7:0]};
        cnt_d  = s1_qm[8] ? (cnt_q + disp) : (cnt_q - disp);
      end else if ((cnt_pos && (n1q > 4'd4)) || (cnt_neg && (n1q < 4'd4))) begin
        dout_d = {1'b1, s1_qm[8], ~s1_qm[7:0]};
        cnt_d  = cnt_q + {3'b000, s1_qm[8], 1'b0} - disp;
      end else begin
        dout_d = {1'b0, s1_qm[8], s1_qm[7:0]};
        cnt_d  = cnt_q - {3'b000, ~s1_qm[8], 1'b0} + disp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q     <= RST_SYMBOL;
      dout_vde_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      dout_q     <= dout_d;
      dout_vde_q <= dout_vde_d;
      cnt_q      <= cnt_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vde = dout_vde_q;

endmodule

// File: tb/tb_tmds_encoder.sv
// Self-checking bench for tmds_encoder: directed vectors with hand-derived
// symbols, then random bytes against a behavioural encoder model.
module tb_tmds_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ce;
  logic       vde;
  logic [7:0] din;
  logic [1:0] ctrl;
  logic [9:0] dout;
  logic       dout_vde;

  int checks = 0;
  int errors = 0;
  int modelCnt = 0;

  always #5 clk = ~clk;

  tmds_encoder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .vde      (vde),
    .din      (din),
    .ctrl     (ctrl),
    .dout     (dout),
    .dout_vde (dout_vde)
  );

  task automatic checkOutput(input string tag, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [1:0] c);
    vde  = v;
    din  = d;
    ctrl = c;
    @(posedge clk);
    #1;
  endtask

  task automatic runVector(input logic v, input logic [7:0] d, input logic [1:0] c,
                           input logic [9:0] expDout, input logic expVde, input string tag);
    applyStimulus(v, d, c);
    checkOutput({tag, "_dout"}, dout, expDout);
    checkOutput({tag, "_vde"}, {9'b0, dout_vde}, {9'b0, expVde});
  endtask

  task automatic checkCnt(input string tag, input int expCnt);
    logic [4:0] e;
    e = 5'(expCnt);
    checkOutput({tag, "_cnt"}, {5'b0, dut.cnt_q}, {5'b0, e});
  endtask

  // Behavioural encoder written straight from the DVI rules with integer disparity.
  task automatic modelEncode(input logic v, input logic [7:0] d, input logic [1:0] c,
                             output logic [9:0] sym);
    int n1, n1q, n0q, b8;
    logic xn;
    logic [8:0] q;
    n1 = $countones(d);
    xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~xn;
    b8  = q[8] ? 1 : 0;
    n1q = $countones(q[7:0]);
    n0q = 8 - n1q;
    if (!v) begin
      modelCnt = 0;
      case (c)
        2'b00: sym = 10'h354;
        2'b01: sym = 10'h0AB;
        2'b10: sym = 10'h154;
        default: sym = 10'h2AB;
      endcase
    end else if (modelCnt == 0 || n1q == n0q) begin
      sym = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
      modelCnt += (b8 == 1) ? (n1q - n0q) : (n0q - n1q);
    end else if ((modelCnt > 0 && n1q > n0q) || (modelCnt < 0 && n0q > n1q)) begin
      sym = {1'b1, q[8], ~q[7:0]};
      modelCnt += 2 * b8 + (n0q - n1q);
    end else begin
      sym = {1'b0, q[8], q[7:0]};
      modelCnt += -2 * (1 - b8) + (n1q - n0q);
    end
  endtask

  initial begin
    logic [9:0] curSym, prevSym;
    logic       curVde, prevVde;
    int         curCnt, prevCnt;
    logic       rv;
    logic [7:0] rd;
    logic [1:0] rc;
    logic       inRange;

    rst_n = 1'b0;
    ce    = 1'b1;
    vde   = 1'b1;
    din   = 8'hAA;
    ctrl  = 2'b00;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("reset_dout", dout, 10'h354);
      checkOutput("reset_vde", {9'b0, dout_vde}, 10'h000);
    end
    checkCnt("reset", 0);
    rst_n = 1'b1;

    // Control symbols, then four zero pixels walking the disparity
    runVector(1'b0, 8'h00, 2'b00, 10'h354, 1'b0, "rst_first");
    runVector(1'b0, 8'h00, 2'b01, 10'h354, 1'b0, "ctrl00");
    runVector(1'b0, 8'h00, 2'b10, 10'h0AB, 1'b0, "ctrl01");
    runVector(1'b0, 8'h00, 2'b11, 10'h154, 1'b0, "ctrl10");
    runVector(1'b1, 8'h00, 2'b00, 10'h2AB, 1'b0, "ctrl11");
    runVector(1'b1, 8'h00, 2'b00, 10'h100, 1'b1, "disp0");
    checkCnt("disp0", -8);
    runVector(1'b1, 8'h00, 2'b00, 10'h3FF, 1'b1, "disp1");
    checkCnt("disp1", 2);
    runVector(1'b1, 8'h00, 2'b00, 10'h100, 1'b1, "disp2");
    checkCnt("disp2", -6);
    runVector(1'b0, 8'h00, 2'b00, 10'h3FF, 1'b1, "disp3");
    checkCnt("disp3", 4);

    // XNOR path from a fresh control period
    runVector(1'b1, 8'hFF, 2'b00, 10'h354, 1'b0, "xnor_pre");
    checkCnt("xnor_pre", 0);
    runVector(1'b1, 8'hFF, 2'b00, 10'h200, 1'b1, "xnor0");
    checkCnt("xnor0", -8);
    runVector(1'b0, 8'h00, 2'b00, 10'h0FF, 1'b1, "xnor1");
    checkCnt("xnor1", -2);
    runVector(1'b0, 8'h00, 2'b00, 10'h354, 1'b0, "xnor_post");
    checkCnt("xnor_post", 0);

    // Clock-enable gap with toggling inputs
    runVector(1'b1, 8'h10, 2'b00, 10'h354, 1'b0, "gate_a");
    runVector(1'b1, 8'h33, 2'b00, 10'h1F0, 1'b1, "gate_b");
    ce = 1'b0;
    for (int i = 0; i < 5; i++) begin
      runVector(1'(i % 2), 8'(i * 37 + 5), 2'(i), 10'h1F0, 1'b1, "gate_hold");
    end
    checkCnt("gate_hold", 0);
    ce = 1'b1;
    runVector(1'b0, 8'h00, 2'b01, 10'h111, 1'b1, "gate_resume");
    checkCnt("gate_resume", -4);
    runVector(1'b0, 8'h00, 2'b10, 10'h0AB, 1'b0, "gate_ctrl01");
    runVector(1'b0, 8'h00, 2'b00, 10'h154, 1'b0, "gate_ctrl10");

    // Reset pulse in the middle of an active line
    runVector(1'b1, 8'h00, 2'b00, 10'h354, 1'b0, "mid_a");
    runVector(1'b1, 8'h55, 2'b00, 10'h100, 1'b1, "mid_b");
    rst_n = 1'b0;
    runVector(1'b1, 8'h55, 2'b00, 10'h354, 1'b0, "mid_rst");
    checkCnt("mid_rst", 0);
    rst_n = 1'b1;
    runVector(1'b1, 8'h00, 2'b00, 10'h354, 1'b0, "mid_post0");
    runVector(1'b1, 8'h00, 2'b00, 10'h100, 1'b1, "mid_post1");
    runVector(1'b0, 8'h00, 2'b00, 10'h3FF, 1'b1, "mid_post2");

    // Random bytes against the model, one-symbol pipeline lag
    prevSym = '0;
    prevVde = 1'b0;
    prevCnt = 0;
    for (int i = 0; i < 1000; i++) begin
      rv = (i == 0) ? 1'b0 : ($urandom_range(0, 7) != 0);
      rd = 8'($urandom_range(0, 255));
      rc = 2'($urandom_range(0, 3));
      modelEncode(rv, rd, rc, curSym);
      curVde = rv;
      curCnt = modelCnt;
      applyStimulus(rv, rd, rc);
      if (i > 0) begin
        checkOutput("rand_dout", dout, prevSym);
        checkOutput("rand_vde", {9'b0, dout_vde}, {9'b0, prevVde});
        checkCnt("rand", prevCnt);
        inRange = ($signed(dut.cnt_q) >= -5'sd10) && ($signed(dut.cnt_q) <= 5'sd10);
        checkOutput("rand_cnt_range", {9'b0, inRange}, 10'h001);
      end
      prevSym = curSym;
      prevVde = curVde;
      prevCnt = curCnt;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
